wishbone_uart_rx: RTL

- Receive-side counterpart of the Wishbone UART TX slave: deserialises 8N1 frames from `ser_rx` and buffers received bytes in a small FIFO.
- Exposes a data register and a status register to the CPU over a Wishbone slave port.
- Sits on the same Wishbone interconnect as the TX slave.
- Uses the same bit period as the TX slave, so a TX-to-RX loopback is bit-exact.

---
 rtl/wishbone_uart_rx_pkg.sv | 32 +++
 rtl/wishbone_uart_rx_if.sv | 25 ++
 rtl/uart_rx_fifo.sv | 56 +++++
 rtl/wishbone_uart_rx.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/wishbone_uart_rx_pkg.sv
// Shared constants, register map and FSM state type for the Wishbone UART receiver.
package wishbone_uart_rx_pkg;

  localparam logic RST_ENABLE = 1'b0;

  localparam int WB_DATA_W = 32;
  localparam int WB_SEL_W  = 4;

  localparam logic [WB_DATA_W-1:0] UART_RX_DATA_OFFSET   = 32'h0000_0000;
  localparam logic [WB_DATA_W-1:0] UART_RX_STATUS_OFFSET = 32'h0000_0004;

  localparam int STAT_VALID_BIT     = 0;
  localparam int STAT_OVERRUN_BIT   = 1;
  localparam int STAT_FRAME_ERR_BIT = 2;
  localparam int STAT_COUNT_LSB     = 4;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  function automatic logic [WB_DATA_W-1:0] pack_status(input logic [3:0] count,
                                                        input logic       frame_err,
                                                        input logic       overrun,
                                                        input logic       valid);
    return {24'b0, count, 1'b0, frame_err, overrun, valid};
  endfunction

endpackage

// File: rtl/wishbone_uart_rx_if.sv
// Wishbone slave-side signal bundle shared by the CPU interconnect and the UART RX block.
interface wishbone_uart_rx_if;
  import wishbone_uart_rx_pkg::*;

  logic [WB_DATA_W-1:0] wishbone_addr_i;
  logic [WB_DATA_W-1:0] wishbone_data_i;
  logic                 wishbone_we_i;
  logic [WB_SEL_W-1:0]  wishbone_sel_i;
  logic                 wishbone_stb_i;
  logic                 wishbone_cyc_i;
  logic [WB_DATA_W-1:0] wishbone_data_o;
  logic                 wishbone_ack_o;

  modport master (
    output wishbone_addr_i, wishbone_data_i, wishbone_we_i, wishbone_sel_i,
           wishbone_stb_i, wishbone_cyc_i,
    input  wishbone_data_o, wishbone_ack_o
  );

  modport slave (
    input  wishbone_addr_i, wishbone_data_i, wishbone_we_i, wishbone_sel_i,
           wishbone_stb_i, wishbone_cyc_i,
    output wishbone_data_o, wishbone_ack_o
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Synchronous byte FIFO; head is combinational from the read pointer.
// A pop in the same cycle as a push into a full FIFO frees the slot so the push is kept.
module uart_rx_fifo
  import wishbone_uart_rx_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_push,
  input  logic        i_pop,
  input  logic [7:0]  i_din,
  output logic [7:0]  o_head,
  output logic [AW:0] o_count,
  output logic        o_full,
  output logic        o_empty
);

  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_pop;
  logic          w_do_push;

  assign o_count   = r_count;
  assign o_full    = (r_count == CNT_FULL);
  assign o_empty   = (r_count == '0);
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk or negedge resetn) begin
    if (resetn == RST_ENABLE) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/wishbone_uart_rx.sv
// 8N1 UART receiver with RX FIFO behind a Wishbone slave (RXDATA at +0x0, STATUS at +0x4).
// Byte shows in STATUS 1 cycle after the stop-bit sample; every bus request is acked one cycle later.
module wishbone_uart_rx
  import wishbone_uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 262,
  parameter int FIFO_DEPTH   = 8,
  parameter int FIFO_AW      = 3
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            ser_rx,
  wishbone_uart_rx_if.slave wb
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST    = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]     r_sync;
  logic           w_rx_s;
  rx_state_t      r_state, w_state_nxt;
  logic [CW-1:0]  r_cnt, w_cnt_nxt;
  logic [2:0]     r_bitidx, w_bitidx_nxt;
  logic [7:0]     r_shift, w_shift_nxt;
  logic           w_push, w_ferr_set;

  logic [7:0]         w_head;
  logic [FIFO_AW:0]   w_count;
  logic               w_full, w_empty;
  logic               r_overrun, r_frame_err;
  logic               r_ack;
  logic [WB_DATA_W-1:0] r_dat, w_rd_dat;
  logic w_take, w_is_stat, w_pop, w_ovr_set, w_clr_ovr, w_clr_ferr;
  logic w_unused_ok;

  always_ff @(posedge clk or negedge resetn) begin
    if (resetn == RST_ENABLE) r_sync <= 2'b11;
    else                      r_sync <= {r_sync[0], ser_rx};
  end
  assign w_rx_s = r_sync[1];

  always_ff @(posedge clk or negedge resetn) begin
    if (resetn == RST_ENABLE) begin
      r_state  <= RX_IDLE;
      r_cnt    <= '0;
      r_bitidx <= '0;
      r_shift  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_bitidx <= w_bitidx_nxt;
      r_shift  <= w_shift_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_bitidx_nxt = r_bitidx;
    w_shift_nxt  = r_shift;
    w_push       = 1'b0;
    w_ferr_set   = 1'b0;
    case (r_state)
      RX_IDLE: begin
        w_cnt_nxt = '0;
        if (!w_rx_s) w_state_nxt = RX_START;
      end
      RX_START: begin
        // Re-check mid start bit so short low glitches are rejected
        if (r_cnt == CNT_HALF_M1) begin
          w_cnt_nxt    = '0;
          w_bitidx_nxt = '0;
          w_state_nxt  = w_rx_s ? RX_IDLE : RX_DATA;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_nxt    = '0;
          w_shift_nxt  = {w_rx_s, r_shift[7:1]};
          w_bitidx_nxt = r_bitidx + 1'b1;
          if (r_bitidx == 3'd7) w_state_nxt = RX_STOP;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_nxt = '0;
          if (w_rx_s) begin
            w_push      = 1'b1;
            w_state_nxt = RX_IDLE;
          end else begin
            w_ferr_set  = 1'b1;
            w_state_nxt = RX_WAIT_HIGH;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      RX_WAIT_HIGH: begin
        if (w_rx_s) w_state_nxt = RX_IDLE;
      end
      default: w_state_nxt = RX_IDLE;
    endcase
  end

  uart_rx_fifo #(.DEPTH(FIFO_DEPTH), .AW(FIFO_AW)) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (r_shift),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_take     = wb.wishbone_cyc_i & wb.wishbone_stb_i & ~r_ack;
  assign w_is_stat  = wb.wishbone_addr_i[2];
  assign w_pop      = w_take & ~wb.wishbone_we_i & ~w_is_stat & ~w_empty;
  assign w_clr_ovr  = w_take & wb.wishbone_we_i & w_is_stat & wb.wishbone_data_i[STAT_OVERRUN_BIT];
  assign w_clr_ferr = w_take & wb.wishbone_we_i & w_is_stat & wb.wishbone_data_i[STAT_FRAME_ERR_BIT];
  assign w_ovr_set  = w_push & w_full & ~w_pop;
  assign w_rd_dat   = w_is_stat ? pack_status(4'(w_count), r_frame_err, r_overrun, ~w_empty)
                                : {24'b0, (w_empty ? 8'h00 : w_head)};

  always_ff @(posedge clk or negedge resetn) begin
    if (resetn == RST_ENABLE) begin
      r_ack <= 1'b0;
      r_dat <= '0;
    end else if (w_take) begin
      r_ack <= 1'b1;
      r_dat <= w_rd_dat;
    end else begin
      r_ack <= 1'b0;
    end
  end

  // Set has priority over a coincident write-1-to-clear
  always_ff @(posedge clk or negedge resetn) begin
    if (resetn == RST_ENABLE) begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_ovr_set)       r_overrun <= 1'b1;
      else if (w_clr_ovr)  r_overrun <= 1'b0;
      if (w_ferr_set)      r_frame_err <= 1'b1;
      else if (w_clr_ferr) r_frame_err <= 1'b0;
    end
  end

  assign wb.wishbone_ack_o  = r_ack;
  assign wb.wishbone_data_o = r_dat;
  assign w_unused_ok = ^{wb.wishbone_addr_i[31:3], wb.wishbone_addr_i[1:0],
                         wb.wishbone_data_i[31:3], wb.wishbone_data_i[0], wb.wishbone_sel_i};

endmodule
